// File: rtl/odesa_pkg.sv
// rtl/odesa_pkg.sv - shared widths, one-hot constants, output FSM states and index helpers
package odesa_pkg;
    localparam int c_idx_w  = 4;
    localparam int c_addr_w = 2;
    localparam int c_drop_w = 8;

    localparam logic [c_idx_w-1:0] c_oh_0 = 4'b0001;
    localparam logic [c_idx_w-1:0] c_oh_1 = 4'b0010;
    localparam logic [c_idx_w-1:0] c_oh_2 = 4'b0100;
    localparam logic [c_idx_w-1:0] c_oh_3 = 4'b1000;

    typedef enum logic {ST_EMPTY, ST_HOLD} out_state_t;

    function automatic logic f_is_onehot(input logic [c_idx_w-1:0] idx);
        return (idx != '0) && ((idx & (idx - c_idx_w'(1))) == '0);
    endfunction

    function automatic logic [c_addr_w-1:0] f_encode(input logic [c_idx_w-1:0] idx);
        logic [c_addr_w-1:0] addr;
        addr = '0;
        case (idx)
            c_oh_1:  addr = 2'd1;
            c_oh_2:  addr = 2'd2;
            c_oh_3:  addr = 2'd3;
            default: addr = 2'd0;
        endcase
        return addr;
    endfunction
endpackage

// File: rtl/winner_aer_tx_if.sv
// rtl/winner_aer_tx_if.sv - winner input strobe and AER output handshake bundle
interface winner_aer_tx_if
    import odesa_pkg::*;
#(
    parameter int p_width    = 19,
    parameter int p_ts_width = 16
);
    logic                  i_valid;
    logic [c_idx_w-1:0]    i_index;
    logic [p_width-1:0]    i_result;
    logic                  i_ready;
    logic                  o_valid;
    logic [c_addr_w-1:0]   o_addr;
    logic [p_width-1:0]    o_value;
    logic [p_ts_width-1:0] o_ts;

    modport slave (
        input  i_valid, i_index, i_result, i_ready,
        output o_valid, o_addr, o_value, o_ts
    );

    modport master (
        output i_valid, i_index, i_result, i_ready,
        input  o_valid, o_addr, o_value, o_ts
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-two depth, registered count and full flag
module sync_fifo #(
    parameter int p_dw    = 8,
    parameter int p_depth = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [p_dw-1:0]            i_data,
    input  logic                       i_pop,
    output logic [p_dw-1:0]            o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(p_depth):0]   o_count
);
    localparam int c_aw = $clog2(p_depth);
    localparam int c_cw = c_aw + 1;

    logic [p_dw-1:0] r_mem [p_depth];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] w_count_nxt;
    logic            r_full;

    always_comb begin
        w_count_nxt = r_count;
        if (i_push && !i_pop) begin
            w_count_nxt = r_count + c_cw'(1);
        end else if (!i_push && i_pop) begin
            w_count_nxt = r_count - c_cw'(1);
        end
    end

    // Pointers wrap for free because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_cw'(p_depth));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/winner_aer_tx.sv
// rtl/winner_aer_tx.sv - one-hot winner to AER event queue with overflow/error counters
// Optional capture timestamp enabled by WINNER_AER_TS_EN.
module winner_aer_tx
    import odesa_pkg::*;
#(
    parameter int p_width    = 19,
    parameter int p_depth    = 4,
    parameter int p_ts_width = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    winner_aer_tx_if.slave      bus,
    output logic                o_full,
    output logic [c_drop_w-1:0] o_drop_cnt,
    output logic                o_err
);
    localparam int c_cw = $clog2(p_depth) + 1;
`ifdef WINNER_AER_TS_EN
    localparam int c_dw = c_addr_w + p_width + p_ts_width;
`else
    localparam int c_dw = c_addr_w + p_width;
`endif

    out_state_t            r_state;
    out_state_t            w_state_nxt;
    logic [c_drop_w-1:0]   r_drop;
    logic                  r_err;
    logic                  w_onehot;
    logic                  w_event;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [c_cw-1:0]       w_count;
    logic [c_dw-1:0]       w_wdata;
    logic [c_dw-1:0]       w_rdata;
    logic [c_addr_w-1:0]   w_rd_addr;
    logic [p_width-1:0]    w_rd_value;
    logic [p_ts_width-1:0] w_rd_ts;

    assign w_onehot = f_is_onehot(bus.i_index);
    assign w_event  = bus.i_valid && w_onehot;
    assign w_pop    = (r_state == ST_HOLD) && !w_empty && bus.i_ready;
    // A full queue still takes a new event when the head leaves in the same cycle.
    assign w_push   = w_event && (!w_full || w_pop);

`ifdef WINNER_AER_TS_EN
    logic [p_ts_width-1:0] r_ts;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_ts <= '0;
        else       r_ts <= r_ts + p_ts_width'(1);
    end

    assign w_wdata = {f_encode(bus.i_index), bus.i_result, r_ts};
    assign {w_rd_addr, w_rd_value, w_rd_ts} = w_rdata;
`else
    assign w_wdata = {f_encode(bus.i_index), bus.i_result};
    assign {w_rd_addr, w_rd_value} = w_rdata;
    assign w_rd_ts = '0;
`endif

    sync_fifo #(
        .p_dw    (c_dw),
        .p_depth (p_depth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_wdata),
        .i_pop   (w_pop),
        .o_data  (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.o_valid  = 1'b0;
        bus.o_addr   = '0;
        bus.o_value  = '0;
        bus.o_ts     = '0;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                bus.o_valid = 1'b1;
                bus.o_addr  = w_rd_addr;
                bus.o_value = w_rd_value;
                bus.o_ts    = w_rd_ts;
                if (w_pop && (w_count == c_cw'(1)) && !w_push) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_event && w_full && !w_pop && (r_drop != '1)) r_drop <= r_drop + c_drop_w'(1);
            if (bus.i_valid && (bus.i_index != '0) && !w_onehot) r_err <= 1'b1;
        end
    end

    assign o_full     = w_full;
    assign o_drop_cnt = r_drop;
    assign o_err      = r_err;
endmodule

// File: tb/tb_winner_aer_tx.sv
// tb/tb_winner_aer_tx.sv - scoreboard bench for winner_aer_tx
module tb_winner_aer_tx;
    import odesa_pkg::*;

    localparam int W = 19;
    localparam int D = 4;
    localparam int TSW = 16;
`ifdef WINNER_AER_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]     addr;
        logic [W-1:0]   value;
        logic [TSW-1:0] ts;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    winner_aer_tx_if #(.p_width(W), .p_ts_width(TSW)) bus ();
    logic       o_full;
    logic       o_err;
    logic [7:0] o_drop_cnt;

    winner_aer_tx #(.p_width(W), .p_depth(D), .p_ts_width(TSW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_full     (o_full),
        .o_drop_cnt (o_drop_cnt),
        .o_err      (o_err)
    );

    ev_t            q[$];
    int             n_checks = 0;
    int             n_pass = 0;
    logic [TSW-1:0] m_ts = '0;
    logic [7:0]     m_drop = '0;
    logic           m_err = 1'b0;
    bit             sb_en = 1'b0;

    function automatic logic [1:0] exp_addr(input logic [3:0] idx);
        case (idx)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Reference model: compares the current outputs, then advances on the inputs about to be clocked.
    always @(negedge clk) begin
        ev_t ev;
        ev_t nev;
        bit  pop;
        bit  push;
        if (rst) begin
            q.delete();
            m_drop = '0;
            m_err  = 1'b0;
            m_ts   = '0;
            sb_en  = 1'b1;
        end else if (sb_en) begin
            ev = (q.size() != 0) ? q[0] : '0;
            n_checks++; if (bus.o_valid !== (q.size() != 0)) $display("FAIL sb_valid got %b want %b", bus.o_valid, q.size() != 0); else n_pass++;
            n_checks++; if (bus.o_addr !== ev.addr) $display("FAIL sb_addr got %0d want %0d", bus.o_addr, ev.addr); else n_pass++;
            n_checks++; if (bus.o_value !== ev.value) $display("FAIL sb_value got %0h want %0h", bus.o_value, ev.value); else n_pass++;
            n_checks++; if (bus.o_ts !== ev.ts) $display("FAIL sb_ts got %0h want %0h", bus.o_ts, ev.ts); else n_pass++;
            n_checks++; if (o_full !== (q.size() == D)) $display("FAIL sb_full got %b want %b", o_full, q.size() == D); else n_pass++;
            n_checks++; if (o_drop_cnt !== m_drop) $display("FAIL sb_drop got %0d want %0d", o_drop_cnt, m_drop); else n_pass++;
            n_checks++; if (o_err !== m_err) $display("FAIL sb_err got %b want %b", o_err, m_err); else n_pass++;
            pop  = (q.size() != 0) && (bus.i_ready === 1'b1);
            push = 1'b0;
            nev  = '0;
            if (bus.i_valid && (bus.i_index != 4'b0000)) begin
                if ($onehot(bus.i_index)) begin
                    if ((q.size() < D) || pop) begin
                        push      = 1'b1;
                        nev.addr  = exp_addr(bus.i_index);
                        nev.value = bus.i_result;
                        nev.ts    = TS_EN ? m_ts : '0;
                    end else if (m_drop != 8'hFF) begin
                        m_drop = m_drop + 8'd1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(nev);
            m_ts = m_ts + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.i_valid  = 1'b0;
        bus.i_index  = 4'b0000;
        bus.i_result = '0;
    endtask

    task automatic drive(input logic [3:0] idx, input logic [W-1:0] val);
        bus.i_valid  = 1'b1;
        bus.i_index  = idx;
        bus.i_result = val;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0001, 19'h1);
        bus.i_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_in();
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.o_valid); else n_pass++;
        n_checks++; if (bus.o_value !== '0) $display("FAIL rst_value got %0h want 0", bus.o_value); else n_pass++;
        n_checks++; if (o_full !== 1'b0) $display("FAIL rst_full got %b want 0", o_full); else n_pass++;
        n_checks++; if (o_drop_cnt !== 8'd0) $display("FAIL rst_drop got %0d want 0", o_drop_cnt); else n_pass++;
        n_checks++; if (o_err !== 1'b0) $display("FAIL rst_err got %b want 0", o_err); else n_pass++;
        tick();
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL rst_ignore_valid got %b want 0", bus.o_valid); else n_pass++;
    endtask

    task automatic test_basic();
        pulse_reset();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 20 && m_ts != 16'd5; i++) tick();
        n_checks++; if (m_ts !== 16'd5) $display("FAIL basic_wait got %0d want 5", m_ts); else n_pass++;
        drive(4'b0100, 19'h1234);
        tick();
        idle_in();
        n_checks++; if (bus.o_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.o_valid); else n_pass++;
        n_checks++; if (bus.o_addr !== 2'd2) $display("FAIL basic_addr got %0d want 2", bus.o_addr); else n_pass++;
        n_checks++; if (bus.o_value !== 19'h1234) $display("FAIL basic_value got %0h want 1234", bus.o_value); else n_pass++;
        n_checks++; if (bus.o_ts !== (TS_EN ? 16'd5 : 16'd0)) $display("FAIL basic_ts got %0d want %0d", bus.o_ts, TS_EN ? 5 : 0); else n_pass++;
        tick();
    endtask

    task automatic test_overflow();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001 << (i % 4), 19'(100 + i));
            tick();
            if (i == 3) begin
                n_checks++; if (o_full !== 1'b1) $display("FAIL ovf_full got %b want 1", o_full); else n_pass++;
            end
        end
        idle_in();
        n_checks++; if (o_drop_cnt !== 8'd1) $display("FAIL ovf_drop got %0d want 1", o_drop_cnt); else n_pass++;
        n_checks++; if (bus.o_value !== 19'd100) $display("FAIL ovf_head got %0d want 100", bus.o_value); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        bus.i_ready = 1'b1;
        drive(4'b0010, 19'd200);
        tick();
        idle_in();
        n_checks++; if (o_drop_cnt !== 8'd1) $display("FAIL ppf_drop got %0d want 1", o_drop_cnt); else n_pass++;
        n_checks++; if (o_full !== 1'b1) $display("FAIL ppf_full got %b want 1", o_full); else n_pass++;
        n_checks++; if (bus.o_value !== 19'd101) $display("FAIL ppf_next got %0d want 101", bus.o_value); else n_pass++;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL ppf_drain got %b want 0", bus.o_valid); else n_pass++;
    endtask

    task automatic test_err();
        drive(4'b0110, 19'd7);
        tick();
        idle_in();
        n_checks++; if (o_err !== 1'b1) $display("FAIL err_set got %b want 1", o_err); else n_pass++;
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL err_noevent got %b want 0", bus.o_valid); else n_pass++;
        drive(4'b0000, 19'd9);
        tick();
        idle_in();
        tick();
        n_checks++; if (o_err !== 1'b1) $display("FAIL err_sticky got %b want 1", o_err); else n_pass++;
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL err_zero_idx got %b want 0", bus.o_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b1000, 19'(40 + i));
            tick();
        end
        drive(4'b1000, 19'd55);
        pulse_reset();
        idle_in();
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", bus.o_valid); else n_pass++;
        n_checks++; if (bus.o_addr !== 2'd0) $display("FAIL rmid_addr got %0d want 0", bus.o_addr); else n_pass++;
        n_checks++; if (o_err !== 1'b0) $display("FAIL rmid_err got %b want 0", o_err); else n_pass++;
        drive(4'b0001, 19'd77);
        tick();
        idle_in();
        n_checks++; if (bus.o_value !== 19'd77) $display("FAIL rmid_value got %0d want 77", bus.o_value); else n_pass++;
        n_checks++; if (bus.o_ts !== 16'd0) $display("FAIL rmid_ts got %0d want 0", bus.o_ts); else n_pass++;
        bus.i_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(4'b0001 << (i % 4), 19'(300 + i));
            tick();
            n_checks++; if (bus.o_value !== 19'(300 + i)) $display("FAIL b2b_value got %0d want %0d", bus.o_value, 300 + i); else n_pass++;
        end
        idle_in();
        tick();
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", bus.o_valid); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.i_valid  = 1'($urandom_range(0, 1));
            bus.i_index  = (($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : (4'b0001 << $urandom_range(0, 3)));
            bus.i_result = 19'($urandom);
            bus.i_ready  = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        idle_in();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL rnd_drain got %b want 0", bus.o_valid); else n_pass++;
    endtask

    task automatic test_ts_wrap();
        int n;
        pulse_reset();
        bus.i_ready = 1'b1;
        n = 0;
        while (m_ts != 16'hFFFF && n < 70000) begin
            tick();
            n++;
        end
        n_checks++; if (m_ts !== 16'hFFFF) $display("FAIL wrap_wait got %0h want ffff", m_ts); else n_pass++;
        bus.i_ready = 1'b0;
        drive(4'b0001, 19'd1);
        tick();
        drive(4'b0010, 19'd2);
        tick();
        idle_in();
        n_checks++; if (bus.o_ts !== (TS_EN ? 16'hFFFF : 16'h0)) $display("FAIL wrap_hi got %0h want %0h", bus.o_ts, TS_EN ? 16'hFFFF : 16'h0); else n_pass++;
        bus.i_ready = 1'b1;
        tick();
        n_checks++; if (bus.o_value !== 19'd2) $display("FAIL wrap_second got %0d want 2", bus.o_value); else n_pass++;
        n_checks++; if (bus.o_ts !== 16'h0) $display("FAIL wrap_lo got %0h want 0", bus.o_ts); else n_pass++;
        tick();
    endtask

    initial begin
        idle_in();
        bus.i_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_full();
        test_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_ts_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
